// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory bus controller: region decode, I/O register
// offsets, controller state encoding and the data returned on an aborted access.
package cpu_mem_pkg;

  localparam int          RAM_AW_DEF      = 10;
  localparam logic [15:0] IO_BASE_DEF     = 16'hFF00;
  localparam int          IO_SIZE         = 16;
  localparam int          EXT_TIMEOUT_DEF = 15;

  localparam logic [3:0] IO_OUT  = 4'd0;
  localparam logic [3:0] IO_IN   = 4'd1;
  localparam logic [3:0] IO_STAT = 4'd2;

  localparam logic [7:0] ERR_DATA = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_EXT_WAIT
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_EXT
  } region_t;

  // RAM occupies the bottom of the map; the I/O window is IO_SIZE bytes at io_base.
  function automatic region_t decode_region(input logic [15:0] addr, input int ram_aw,
                                            input logic [15:0] io_base);
    if (32'(addr) < (32'd1 << ram_aw))
      return REG_RAM;
    else if ((addr >= io_base) && (32'(addr) <= 32'(io_base) + 32'(IO_SIZE - 1)))
      return REG_IO;
    else
      return REG_EXT;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM, 8-bit wide, read-first, registered read port.
module sp_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: decodes CPU strobes into internal RAM, a 16-byte I/O bank
// and an external req/ack bus with timeout; returns registered read data.
module mem_bus_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int          RAM_AW      = RAM_AW_DEF,
  parameter logic [15:0] IO_BASE     = IO_BASE_DEF,
  parameter int          EXT_TIMEOUT = EXT_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  data_bus,
  output logic        mem_ready,
  input  logic [7:0]  in_port,
  output logic [7:0]  out_port,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err
);

  localparam int             CW       = $clog2(EXT_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(EXT_TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ext_req_reg, ext_req_next;
  logic          ext_we_reg, ext_we_next;
  logic [15:0]   ext_addr_reg, ext_addr_next;
  logic [7:0]    ext_wdata_reg, ext_wdata_next;
  logic [7:0]    data_reg, data_next;
  logic          sel_ram_reg, sel_ram_next;
  logic          ready_reg, ready_next;
  logic          err_reg, err_next;
  logic [7:0]    out_reg, out_next;
  logic [7:0]    sync1_reg, sync2_reg;

  region_t    region;
  logic [3:0] io_off;
  logic [7:0] io_rdata;
  logic       ram_we, ram_re;
  logic [7:0] ram_rdata;

  assign region = decode_region(mem_addr, RAM_AW, IO_BASE);
  assign io_off = mem_addr[3:0] - IO_BASE[3:0];

  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      IO_OUT:  io_rdata = out_reg;
      IO_IN:   io_rdata = sync2_reg;
      IO_STAT: io_rdata = {7'b0, err_reg};
      default: io_rdata = 8'h00;
    endcase
  end

  sp_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (mem_addr[RAM_AW-1:0]),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  // RAM read data stays in the RAM's own output register; sel_ram picks it
  // until a later non-RAM read completes.
  assign data_bus  = sel_ram_reg ? ram_rdata : data_reg;
  assign mem_ready = ready_reg;
  assign out_port  = out_reg;
  assign ext_req   = ext_req_reg;
  assign ext_we    = ext_we_reg;
  assign ext_addr  = ext_addr_reg;
  assign ext_wdata = ext_wdata_reg;
  assign bus_err   = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      ext_req_reg   <= 1'b0;
      ext_we_reg    <= 1'b0;
      ext_addr_reg  <= 16'h0000;
      ext_wdata_reg <= 8'h00;
      data_reg      <= 8'h00;
      sel_ram_reg   <= 1'b0;
      ready_reg     <= 1'b0;
      err_reg       <= 1'b0;
      out_reg       <= 8'h00;
      sync1_reg     <= 8'h00;
      sync2_reg     <= 8'h00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ext_req_reg   <= ext_req_next;
      ext_we_reg    <= ext_we_next;
      ext_addr_reg  <= ext_addr_next;
      ext_wdata_reg <= ext_wdata_next;
      data_reg      <= data_next;
      sel_ram_reg   <= sel_ram_next;
      ready_reg     <= ready_next;
      err_reg       <= err_next;
      out_reg       <= out_next;
      sync1_reg     <= in_port;
      sync2_reg     <= sync1_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ext_req_next   = ext_req_reg;
    ext_we_next    = ext_we_reg;
    ext_addr_next  = ext_addr_reg;
    ext_wdata_next = ext_wdata_reg;
    data_next      = data_reg;
    sel_ram_next   = sel_ram_reg;
    ready_next     = 1'b0;
    err_next       = err_reg;
    out_next       = out_reg;
    ram_we         = 1'b0;
    ram_re         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (mem_write || mem_read) begin
          case (region)
            REG_RAM: begin
              ready_next = 1'b1;
              if (mem_write) begin
                ram_we = 1'b1;
              end else begin
                ram_re       = 1'b1;
                sel_ram_next = 1'b1;
              end
            end
            REG_IO: begin
              ready_next = 1'b1;
              if (mem_write) begin
                if (io_off == IO_OUT)
                  out_next = wdata;
                else if (io_off == IO_STAT && wdata[0])
                  err_next = 1'b0;
              end else begin
                data_next    = io_rdata;
                sel_ram_next = 1'b0;
              end
            end
            default: begin
              state_next     = ST_EXT_WAIT;
              cnt_next       = '0;
              ext_req_next   = 1'b1;
              ext_we_next    = mem_write;
              ext_addr_next  = mem_addr;
              ext_wdata_next = wdata;
            end
          endcase
        end
      end
      ST_EXT_WAIT: begin
        if (ext_ack) begin
          ext_req_next = 1'b0;
          ready_next   = 1'b1;
          state_next   = ST_IDLE;
          if (!ext_we_reg) begin
            data_next    = ext_rdata;
            sel_ram_next = 1'b0;
          end
        end else if (cnt_reg == CNT_LAST) begin
          ext_req_next = 1'b0;
          ready_next   = 1'b1;
          err_next     = 1'b1;
          state_next   = ST_IDLE;
          if (!ext_we_reg) begin
            data_next    = ERR_DATA;
            sel_ram_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
